// File: rtl/packet_generator_scheduler.sv
// Frame sequencer for the byte shift-out stage: arbitrates between the DLLP and
// TLP sources, drives the shifter load/select controls, and produces qualifiers
// (valid/sof/eof/type) that line up with the shifter's output byte.
module packet_generator_scheduler #(
    parameter int unsigned DLLP_FRAME_WIDTH = 16,
    parameter int unsigned TLP_FRAME_WIDTH  = 64,
    parameter int unsigned DLLP_BURST_MAX   = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tx_en,
    input  logic i_dllp_valid,
    output logic o_dllp_ready,
    input  logic i_tlp_valid,
    output logic o_tlp_ready,
    output logic o_load_frame,
    output logic o_sel_dllp,
    output logic o_byte_valid,
    output logic o_sof,
    output logic o_eof,
    output logic o_is_dllp,
    output logic o_busy
);

    localparam int unsigned DLLP_BYTES_RAW = (DLLP_FRAME_WIDTH + 7) / 8;
    localparam int unsigned TLP_BYTES_RAW  = (TLP_FRAME_WIDTH + 7) / 8;
    localparam int unsigned DLLP_BYTES     = (DLLP_BYTES_RAW < 1) ? 1 : DLLP_BYTES_RAW;
    localparam int unsigned TLP_BYTES      = (TLP_BYTES_RAW < 1) ? 1 : TLP_BYTES_RAW;
    localparam int unsigned MAX_BYTES      = (DLLP_BYTES > TLP_BYTES) ? DLLP_BYTES : TLP_BYTES;
    localparam int unsigned CNT_W          = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int unsigned BURST_W        = 8;

    localparam logic [CNT_W-1:0]   DLLP_LAST   = CNT_W'(DLLP_BYTES - 1);
    localparam logic [CNT_W-1:0]   TLP_LAST    = CNT_W'(TLP_BYTES - 1);
    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(DLLP_BURST_MAX);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               is_dllp_r;
    logic               is_dllp_nxt;
    logic               sof_r;
    logic               sof_nxt;
    logic [BURST_W-1:0] burst;
    logic [BURST_W-1:0] burst_nxt;
    logic               elig;
    logic               gnt_dllp;
    logic               gnt_tlp;

    // Arbitration, shifter controls and next-state computation
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        is_dllp_nxt  = is_dllp_r;
        sof_nxt      = 1'b0;
        burst_nxt    = burst;
        elig         = 1'b0;
        gnt_dllp     = 1'b0;
        gnt_tlp      = 1'b0;
        o_load_frame = 1'b0;
        o_sel_dllp   = 1'b0;
        o_dllp_ready = 1'b0;
        o_tlp_ready  = 1'b0;

        // A new frame may start when idle or on the last byte of the current one
        elig = i_rst_n & i_tx_en & ((state == IDLE) | ((state == SHIFT) & (cnt == '0)));

        if (elig) begin
            if (i_dllp_valid && (!i_tlp_valid || (burst != BURST_LIMIT))) begin
                gnt_dllp = 1'b1;
            end else if (i_tlp_valid) begin
                gnt_tlp = 1'b1;
            end
        end

        o_load_frame = gnt_dllp | gnt_tlp;
        o_sel_dllp   = gnt_dllp;
        o_dllp_ready = gnt_dllp;
        o_tlp_ready  = gnt_tlp;

        if (gnt_dllp) begin
            state_nxt   = SHIFT;
            cnt_nxt     = DLLP_LAST;
            is_dllp_nxt = 1'b1;
            sof_nxt     = 1'b1;
            // Only consecutive DLLP wins against a waiting TLP count toward the burst
            if (i_tlp_valid && (burst < BURST_LIMIT)) begin
                burst_nxt = burst + BURST_W'(1);
            end
        end else if (gnt_tlp) begin
            state_nxt   = SHIFT;
            cnt_nxt     = TLP_LAST;
            is_dllp_nxt = 1'b0;
            sof_nxt     = 1'b1;
            burst_nxt   = '0;
        end else if (state == SHIFT) begin
            if (cnt != '0) begin
                cnt_nxt = cnt - CNT_W'(1);
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    // State, byte counter, frame type, start marker and burst counter registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            is_dllp_r <= 1'b0;
            sof_r     <= 1'b0;
            burst     <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            is_dllp_r <= is_dllp_nxt;
            sof_r     <= sof_nxt;
            burst     <= burst_nxt;
        end
    end

    // Byte qualifiers decoded straight from the registered state
    assign o_byte_valid = (state == SHIFT);
    assign o_busy       = (state == SHIFT);
    assign o_sof        = sof_r;
    assign o_eof        = (state == SHIFT) && (cnt == '0);
    assign o_is_dllp    = is_dllp_r;

endmodule

// File: tb/tb_packet_generator_scheduler.sv
// Directed bench for packet_generator_scheduler: default-sized instance plus a
// 1-byte-DLLP instance; grants and byte qualifiers checked against queues.
module tb_packet_generator_scheduler;

    localparam int unsigned DB = 2;
    localparam int unsigned TB = 8;

    typedef struct packed {
        logic sof;
        logic eof;
        logic dllp;
    } byte_t;

    logic clk;
    logic rst_n;
    logic tx_en, dv, tv;
    logic dr, tr, ld, sel, bv, sof, eof, isd, busy;
    logic tx_en1, dv1, tv1;
    logic dr1, tr1, ld1, sel1, bv1, sof1, eof1, isd1, busy1;

    int n_checks = 0;
    int n_fail   = 0;
    logic mon_en = 1'b0;

    byte_t exp_q[$];
    logic  gnt_q[$];
    byte_t e;
    logic  g;

    packet_generator_scheduler u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_en(tx_en),
        .i_dllp_valid(dv), .o_dllp_ready(dr),
        .i_tlp_valid(tv), .o_tlp_ready(tr),
        .o_load_frame(ld), .o_sel_dllp(sel),
        .o_byte_valid(bv), .o_sof(sof), .o_eof(eof),
        .o_is_dllp(isd), .o_busy(busy)
    );

    packet_generator_scheduler #(.DLLP_FRAME_WIDTH(8)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_en(tx_en1),
        .i_dllp_valid(dv1), .o_dllp_ready(dr1),
        .i_tlp_valid(tv1), .o_tlp_ready(tr1),
        .o_load_frame(ld1), .o_sel_dllp(sel1),
        .o_byte_valid(bv1), .o_sof(sof1), .o_eof(eof1),
        .o_is_dllp(isd1), .o_busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected grant type plus one qualifier record per byte of the frame
    task automatic push_grant(input logic d, input int unsigned n);
        byte_t b;
        gnt_q.push_back(d);
        for (int i = 0; i < int'(n); i++) begin
            b.sof  = (i == 0);
            b.eof  = (i == int'(n) - 1);
            b.dllp = d;
            exp_q.push_back(b);
        end
    endtask

    // Mid-cycle monitor of the default instance: pops expected grants and bytes
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy_eq_valid", 32'(busy), 32'(bv));
            if (bv === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 32'(bv), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte_sof", 32'(sof), 32'(e.sof));
                    chk("byte_eof", 32'(eof), 32'(e.eof));
                    chk("byte_is_dllp", 32'(isd), 32'(e.dllp));
                end
            end else begin
                chk("idle_sof_eof", 32'({sof, eof}), 32'd0);
            end
            if (ld === 1'b1) begin
                if (gnt_q.size() == 0) begin
                    chk("unexpected_load", 32'(ld), 32'd0);
                end else begin
                    g = gnt_q.pop_front();
                    chk("grant_sel", 32'(sel), 32'(g));
                    chk("grant_dllp_ready", 32'(dr), 32'(g));
                    chk("grant_tlp_ready", 32'(tr), 32'(!g));
                end
            end else begin
                chk("ready_without_load", 32'({dr, tr}), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; tx_en = 1'b0; dv = 1'b0; tv = 1'b0;
        tx_en1 = 1'b0; dv1 = 1'b0; tv1 = 1'b0;
        tick;
        tick;
        chk("reset_outputs", 32'({bv, sof, eof, isd, busy, ld, dr, tr}), 32'd0);
        chk("reset_outputs_1b", 32'({bv1, sof1, eof1, isd1, busy1, ld1, dr1, tr1}), 32'd0);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        tick;

        // Single TLP from idle
        tx_en = 1'b1; tv = 1'b1;
        push_grant(1'b0, TB);
        #1;
        chk("t1_tlp_ready", 32'(tr), 32'd1);
        chk("t1_load", 32'(ld), 32'd1);
        chk("t1_sel", 32'(sel), 32'd0);
        tick;
        tv = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk("t1_valid", 32'(bv), 32'd1);
            chk("t1_sof", 32'(sof), 32'(i == 1));
            chk("t1_eof", 32'(eof), 32'(i == 8));
            chk("t1_is_dllp", 32'(isd), 32'd0);
            tick;
        end
        chk("t1_idle_after", 32'(bv), 32'd0);

        // Both sources valid: D,D,D,D,T,D,D,D,D,T back to back
        dv = 1'b1; tv = 1'b1;
        for (int k = 0; k < 10; k++) begin
            push_grant((k % 5) != 4, ((k % 5) != 4) ? DB : TB);
        end
        for (int c = 0; c <= 24; c++) begin
            if (c > 0) chk("t2_no_gap", 32'(bv), 32'd1);
            tick;
        end
        dv = 1'b0; tv = 1'b0;
        for (int c = 25; c <= 32; c++) begin
            chk("t2_tail_valid", 32'(bv), 32'd1);
            tick;
        end
        chk("t2_idle_after", 32'(bv), 32'd0);
        chk("t2_grants_consumed", 32'(gnt_q.size()), 32'd0);

        // tx_en dropped at byte 3 of a TLP, re-raised on its last byte
        tv = 1'b1;
        push_grant(1'b0, TB);
        tick;                       // t+1
        tv = 1'b0;
        tick;                       // t+2
        tick;                       // t+3
        tx_en = 1'b0;
        tick;                       // t+4
        dv = 1'b1;
        for (int c = 4; c <= 7; c++) begin
            #1;
            chk("t3_no_load_tx_off", 32'(ld), 32'd0);
            chk("t3_frame_continues", 32'(bv), 32'd1);
            tick;
        end
        chk("t3_eof_at_t8", 32'(eof), 32'd1);
        tx_en = 1'b1;
        push_grant(1'b1, DB);
        #1;
        chk("t3_regrant_same_cycle", 32'(dr), 32'd1);
        tick;                       // t+9
        dv = 1'b0;
        chk("t3_dllp_sof", 32'({bv, sof, isd}), 32'b111);
        tick;                       // t+10
        chk("t3_dllp_eof", 32'({bv, eof, isd}), 32'b111);
        tick;                       // t+11
        chk("t3_idle_after", 32'(bv), 32'd0);

        // One-byte DLLPs on the second instance: a load every cycle
        tx_en1 = 1'b1; dv1 = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            if (c == 4) dv1 = 1'b0;
            #1;
            chk("t4_load", 32'({ld1, dr1, sel1}), (c < 4) ? 32'b111 : 32'b000);
            if (c >= 1 && c <= 4) begin
                chk("t4_sof_eof", 32'({bv1, sof1, eof1, isd1}), 32'b1111);
            end else begin
                chk("t4_no_byte", 32'(bv1), 32'd0);
            end
            chk("t4_no_tlp_ready", 32'(tr1), 32'd0);
            tick;
        end

        // Reset pulse during byte 4 of a TLP with a DLLP waiting
        tv = 1'b1;
        push_grant(1'b0, TB);
        tick;                       // t+1
        tv = 1'b0;
        tick;                       // t+2
        tick;                       // t+3
        tick;                       // t+4
        chk("t5_byte4_shown", 32'(bv), 32'd1);
        rst_n = 1'b0;
        dv    = 1'b1;
        #1;
        chk("t5_no_load_in_reset", 32'(ld), 32'd0);
        tick;                       // t+5
        exp_q.delete();
        chk("t5_all_zero_after_reset", 32'({bv, sof, eof, isd, busy, ld, dr, tr}), 32'd0);
        tick;                       // t+6
        rst_n = 1'b1;
        push_grant(1'b1, DB);
        #1;
        chk("t5_grant_after_reset", 32'({ld, dr, sel}), 32'b111);
        tick;                       // t+7
        dv = 1'b0;
        chk("t5_dllp_sof", 32'({bv, sof, isd}), 32'b111);
        tick;                       // t+8
        chk("t5_dllp_eof", 32'({bv, eof}), 32'b11);
        tick;                       // t+9
        chk("t5_idle_after", 32'(bv), 32'd0);

        tick;
        tick;
        chk("final_bytes_consumed", 32'(exp_q.size()), 32'd0);
        chk("final_grants_consumed", 32'(gnt_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
